// File: rtl/click_input_conditioner.sv
// click_input_conditioner
// Front end for the two-player click game. Each raw button (D, E) is
// brought into the clk domain with a two-flop synchronizer, debounced with
// a consecutive-mismatch counter, and rising-edge detected. The result is
// turned into a registered one-cycle click pulse that is gated by en/start.
// A press seen while the round is not running marks a sticky false start
// ("foul") that locks that player out until en is dropped or reset.
module click_input_conditioner #(
    parameter int DB_CYCLES = 4,   // stable cycles needed to change level (2..255)
    parameter int CNT_W     = 8    // debounce counter width, 2**CNT_W > DB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic start,
    input  logic D,
    input  logic E,
    output logic click_d,
    output logic click_e,
    output logic stable_d,
    output logic stable_e,
    output logic foul_d,
    output logic foul_e
);

    // Terminal count of the debounce counter, sized to the counter itself
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    // Largest representable count; the counter holds here rather than wrap
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Channel 0 is player 1 (D), channel 1 is player 2 (E)
    logic [1:0] raw;
    logic [1:0] click;
    logic [1:0] stable;
    logic [1:0] foul;

    assign raw = {E, D};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic             sync1_reg;
            logic             sync2_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             stable_reg;
            logic             stable_prev_reg;
            logic             click_reg;
            logic             foul_reg;
            logic             rise;

            // Two-flop synchronizer; the raw button is used nowhere else
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Debounce: count consecutive cycles where the synchronized input
            // disagrees with the debounced level; flip the level on the last one.
            // Any agreeing cycle restarts the count, so short glitches vanish.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (sync2_reg == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DB_LAST) begin
                    stable_reg <= ~stable_reg;
                    cnt_reg    <= '0;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // One-cycle delayed copy of the debounced level for edge detection
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stable_prev_reg <= 1'b0;
                end else begin
                    stable_prev_reg <= stable_reg;
                end
            end

            // A press is the cycle where the debounced level has just gone high
            assign rise = stable_reg & ~stable_prev_reg;

            // Registered click pulse: only during a running round, and never
            // for a player who has already false-started this round
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    click_reg <= 1'b0;
                end else begin
                    click_reg <= rise & en & start & ~foul_reg;
                end
            end

            // Sticky false-start flag: set by a press while the game is
            // enabled but the round has not started; cleared only by en low
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    foul_reg <= 1'b0;
                end else if (!en) begin
                    foul_reg <= 1'b0;
                end else if (rise && !start) begin
                    foul_reg <= 1'b1;
                end
            end

            assign click[gi]  = click_reg;
            assign stable[gi] = stable_reg;
            assign foul[gi]   = foul_reg;
        end
    endgenerate

    assign click_d  = click[0];
    assign click_e  = click[1];
    assign stable_d = stable[0];
    assign stable_e = stable[1];
    assign foul_d   = foul[0];
    assign foul_e   = foul[1];

endmodule

// File: tb/tb_click_input_conditioner.sv
// Testbench for click_input_conditioner. Every press that should produce a
// click pushes the clock edge on which the pulse is due into a per-player
// queue; a monitor on the falling edge pops those entries and checks that
// each click output is high exactly on the scheduled cycles and low elsewhere.
module tb_click_input_conditioner;

    localparam int DB = 4;
    // Press applied just after edge k -> pulse registered on edge k+1+2+DB
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic reset, en, start, D, E;
    logic click_d, click_e, stable_d, stable_e, foul_d, foul_e;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int pulses_d = 0;
    int pulses_e = 0;
    int q_d[$];
    int q_e[$];
    logic exp_d, exp_e;
    int base_d, base_e;

    click_input_conditioner #(.DB_CYCLES(DB), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .D(D), .E(E),
        .click_d(click_d), .click_e(click_e), .stable_d(stable_d),
        .stable_e(stable_e), .foul_d(foul_d), .foul_e(foul_e)
    );

    // 100 ns clock period
    always #50 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare click outputs against due edges every cycle
    always @(negedge clk) begin
        if (!reset) begin
            while (q_d.size() > 0 && q_d[0] < edge_cnt) void'(q_d.pop_front());
            while (q_e.size() > 0 && q_e[0] < edge_cnt) void'(q_e.pop_front());
            exp_d = (q_d.size() > 0 && q_d[0] == edge_cnt);
            exp_e = (q_e.size() > 0 && q_e[0] == edge_cnt);
            check($sformatf("click_d@%0d", edge_cnt), {31'd0, click_d}, {31'd0, exp_d});
            check($sformatf("click_e@%0d", edge_cnt), {31'd0, click_e}, {31'd0, exp_e});
            if (exp_d) void'(q_d.pop_front());
            if (exp_e) void'(q_e.pop_front());
            if (click_d) begin pulses_d++; $display("edge %0d click_d", edge_cnt); end
            if (click_e) begin pulses_e++; $display("edge %0d click_e", edge_cnt); end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; start = 1'b0; D = 1'b0; E = 1'b0;
        step(2);
        check("rst_click_d", {31'd0, click_d}, 0);
        check("rst_click_e", {31'd0, click_e}, 0);
        check("rst_stable_d", {31'd0, stable_d}, 0);
        check("rst_stable_e", {31'd0, stable_e}, 0);
        check("rst_foul_d", {31'd0, foul_d}, 0);
        check("rst_foul_e", {31'd0, foul_e}, 0);
        reset = 1'b0;
        step(2);

        // Single held press: one pulse, 7 edges after the change
        en = 1'b1; start = 1'b1;
        D = 1'b1; q_d.push_back(edge_cnt + LAT);
        step(20);
        check("hold_stable_d", {31'd0, stable_d}, 1);
        check("hold_foul_d", {31'd0, foul_d}, 0);
        check("hold_pulses_d", pulses_d, 1);
        D = 1'b0;
        step(10);
        check("release_stable_d", {31'd0, stable_d}, 0);

        // Bouncing every clock: never accepted
        for (int i = 0; i < 40; i++) begin
            D = ~D;
            step(1);
            check("toggle_stable_d", {31'd0, stable_d}, 0);
        end
        D = 1'b0;
        step(4);
        // Bursts of 3 high, 1 low: each burst too short
        for (int i = 0; i < 4; i++) begin
            D = 1'b1; step(3);
            check("burst_stable_d", {31'd0, stable_d}, 0);
            D = 1'b0; step(1);
            check("burst_stable_d", {31'd0, stable_d}, 0);
        end
        step(10);
        check("burst_pulses_d", pulses_d, 1);

        // False start on E, then lockout during the round, then en clears it
        start = 1'b0;
        E = 1'b1; step(10);
        check("foul_e_set", {31'd0, foul_e}, 1);
        E = 1'b0; step(10);
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            E = 1'b1; step(10);
            E = 1'b0; step(10);
        end
        check("foul_e_locked", {31'd0, foul_e}, 1);
        check("locked_pulses_e", pulses_e, 0);
        en = 1'b0; step(1);
        en = 1'b1;
        check("foul_e_cleared", {31'd0, foul_e}, 0);
        E = 1'b1; q_e.push_back(edge_cnt + LAT);
        step(10);
        check("after_clear_pulses_e", pulses_e, 1);
        E = 1'b0; step(10);

        // Simultaneous press on both players
        D = 1'b1; E = 1'b1;
        q_d.push_back(edge_cnt + LAT); q_e.push_back(edge_cnt + LAT);
        step(10);
        D = 1'b0; E = 1'b0; step(10);

        // Five separated presses per player
        base_d = pulses_d; base_e = pulses_e;
        for (int i = 0; i < 5; i++) begin
            D = 1'b1; q_d.push_back(edge_cnt + LAT); step(3);
            E = 1'b1; q_e.push_back(edge_cnt + LAT); step(12);
            D = 1'b0; step(3);
            E = 1'b0; step(12);
        end
        check("five_pulses_d", pulses_d - base_d, 5);
        check("five_pulses_e", pulses_e - base_e, 5);

        // Reset in the middle of a held press: re-debounced as a new press
        D = 1'b1; q_d.push_back(edge_cnt + LAT);
        step(15);
        reset = 1'b1;
        #9;
        check("midrst_click_d", {31'd0, click_d}, 0);
        check("midrst_stable_d", {31'd0, stable_d}, 0);
        check("midrst_foul_d", {31'd0, foul_d}, 0);
        check("midrst_stable_e", {31'd0, stable_e}, 0);
        #21;
        reset = 1'b0;
        base_d = pulses_d;
        q_d.push_back(edge_cnt + LAT);
        step(12);
        check("midrst_pulses_d", pulses_d - base_d, 1);
        check("midrst_stable_after", {31'd0, stable_d}, 1);
        D = 1'b0; step(10);

        // start drops while the debounced level is still rising
        base_d = pulses_d;
        D = 1'b1; step(4);
        start = 1'b0;
        step(10);
        check("late_start_foul_d", {31'd0, foul_d}, 1);
        check("late_start_pulses_d", pulses_d - base_d, 0);
        D = 1'b0; step(10);

        check("q_d_drained", q_d.size(), 0);
        check("q_e_drained", q_e.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
